// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage with a small prefetch FIFO and the IF/ID pipeline
//   register. Sits upstream of the hazard controller and decode.
//
//   Optional feature macro: IF_MISALIGN_CHECK_EN
//     defined   : adds registered output fetch_misaligned; a redirect to a
//                 non-word-aligned target flushes but parks fetch until the
//                 next aligned redirect.
//     undefined : redirect_pc[1:0] are masked and the redirect proceeds.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   pc_stall           freeze fetch PC, issue no new request
//   if_id_stall        hold IF/ID register contents
//   if_id_flush        load a bubble into IF/ID (overrides if_id_stall)
//   redirect_valid/pc  taken branch/jump from the branch unit (highest prio)
//   imem_req_*         word fetch request, valid/ready handshake
//   imem_rsp_*         in-order responses, one per accepted request
//   if_id_valid/pc/instr  IF/ID register; instr is NOP_INSTR when invalid
//   fetch_misaligned   (optional) one-cycle pulse after a misaligned redirect
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        if_id_stall,
  input  logic        if_id_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  // FIFO_DEPTH is 2 or 4, so pointers are 1 or 2 bits and counts one more.
  localparam int AW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;       // PC of the next response that will be kept
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];

  logic [31:0]   redir_target;
  logic          redir_mis;
  logic          fetch_halt;
  logic          pop, push, rsp_drop, req_fire;
  logic [CW:0]   occupancy;

  assign redir_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef IF_MISALIGN_CHECK_EN
  logic halted;
  assign redir_mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_halt = halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted           <= 1'b0;
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_misaligned <= redir_mis;
      if (redirect_valid) halted <= redir_mis;
    end
  end
`else
  assign redir_mis  = 1'b0;
  assign fetch_halt = 1'b0;
`endif

  assign rsp_drop = (drop_cnt != '0);
  assign pop      = !redirect_valid && !if_id_flush && !if_id_stall && (fifo_cnt != '0);
  assign push     = imem_rsp_valid && !rsp_drop && !redirect_valid;

  // The entry leaving the FIFO this cycle frees its slot for a new request,
  // which is what allows one instruction per cycle with a 2-deep FIFO and
  // single-cycle memory. A request left waiting on ready stays legal next
  // cycle regardless of pop: that cycle's occupancy can only shrink.
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};

  assign imem_req_valid = !rst && !pc_stall && !redirect_valid && !fetch_halt &&
                          (occupancy < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
        // Everything still in flight is stale; a response arriving right now
        // is discarded directly and so is not counted.
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
        if (!redir_mis) begin
          fetch_pc <= redir_target;
          rsp_pc   <= redir_target;
        end
        fifo_cnt <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (imem_rsp_valid && rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end

      // IF/ID: redirect and flush force a bubble; stall holds; otherwise
      // take the FIFO head or a bubble if nothing is buffered.
      if (redirect_valid || if_id_flush) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (!if_id_stall) begin
        if (fifo_cnt != '0) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= fifo_pc[rd_ptr];
          if_id_instr <= fifo_instr[rd_ptr];
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= rsp_pc;
      fifo_instr[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
